dmi_arbiter: RTL and testbench

- Shares one DMI target port (debug module) between NREQ debug transport requesters, e.g. the UART DTM and a future JTAG DTM.
- Requesters use the codebase DMI style: a one-cycle valid pulse with no backpressure. The arbiter therefore holds one pending request per requester.
- It grants pending requests round-robin and issues each as a one-cycle dmi_valid pulse.
- It samples dmi_rdata after a fixed latency and returns it to the owning requester as a one-cycle response pulse.

---
 rtl/dmi_pkg.sv | 20 ++
 rtl/dmi_arbiter_rr_arbiter.sv | 30 +++
 rtl/dmi_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmi_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared DMI widths, arbiter FSM encoding and request slot type
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dmi_state_e;

    typedef struct packed {
        logic                  wr;
        logic [DMI_ADDR_W-1:0] addr;
        logic [DMI_DATA_W-1:0] wdata;
    } dmi_slot_t;

endpackage

// File: rtl/dmi_arbiter_rr_arbiter.sv
// rtl/dmi_arbiter_rr_arbiter.sv - combinational round-robin pick over a request vector
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] idx;

    // Walk the requesters starting at 'start' and take the first one pending.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDX_W'((int'(start) + k) % NREQ);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/dmi_arbiter.sv
// rtl/dmi_arbiter.sv - shares one DMI target port between NREQ debug transports
module dmi_arbiter
    import dmi_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_wr,
    input  logic [NREQ*DMI_ADDR_W-1:0] req_addr,
    input  logic [NREQ*DMI_DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DMI_DATA_W-1:0]      rsp_rdata,
    output logic [NREQ-1:0]            req_busy,
    output logic [NREQ-1:0]            ovf,
    input  logic [NREQ-1:0]            ovf_clr,
    output logic                       dmi_valid,
    output logic                       dmi_wr,
    output logic [DMI_ADDR_W-1:0]      dmi_addr,
    output logic [DMI_DATA_W-1:0]      dmi_wdata,
    input  logic [DMI_DATA_W-1:0]      dmi_rdata
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = 3;

    dmi_state_e       state, state_nxt;
    dmi_slot_t        slot [NREQ];
    logic [NREQ-1:0]  pending;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] g_idx;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             grant_now;
    logic [NREQ-1:0]  grant_vec;
    logic [NREQ-1:0]  g_onehot;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (pending),
        .start   (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign grant_now = (state == ST_IDLE) && arb_any;
    assign grant_vec = grant_now ? arb_gnt : '0;
    assign g_onehot  = NREQ'(1) << g_idx;

    assign dmi_valid = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP) ? g_onehot : '0;
    assign req_busy  = pending | ((state != ST_IDLE) ? g_onehot : '0);

    // Per-requester slot capture; a slot freed by this cycle's grant may refill at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            ovf     <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && (!pending[i] || grant_vec[i])) begin
                    slot[i]    <= {req_wr[i], req_addr[DMI_ADDR_W*i +: DMI_ADDR_W],
                                   req_wdata[DMI_DATA_W*i +: DMI_DATA_W]};
                    pending[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    pending[i] <= 1'b0;
                end
                if (req_valid[i] && pending[i] && !grant_vec[i]) begin
                    ovf[i] <= 1'b1;
                end else if (ovf_clr[i]) begin
                    ovf[i] <= 1'b0;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: ISSUE always falls into WAIT, which lasts RD_LATENCY cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == CNT_W'(1)) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Issue datapath, round-robin pointer, latency counter and read-data sampling.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dmi_wr    <= 1'b0;
            dmi_addr  <= '0;
            dmi_wdata <= '0;
            rsp_rdata <= '0;
            g_idx     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        dmi_wr    <= slot[arb_idx].wr;
                        dmi_addr  <= slot[arb_idx].addr;
                        dmi_wdata <= slot[arb_idx].wdata;
                        g_idx     <= arb_idx;
                        rr_ptr    <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                        cnt       <= CNT_W'(RD_LATENCY);
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        rsp_rdata <= dmi_rdata;
                    end
                    cnt <= cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb/tb_dmi_arbiter.sv - directed self-checking bench for dmi_arbiter
`timescale 1ns/1ps
module tb_dmi_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_wr = '0;
    logic [13:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  ovf_clr = '0;
    logic [31:0] dmi_rdata1 = '0;
    logic [31:0] dmi_rdata4 = '0;

    logic [1:0]  rsp_valid1, req_busy1, ovf1;
    logic [31:0] rsp_rdata1, dmi_wdata1;
    logic        dmi_valid1, dmi_wr1;
    logic [6:0]  dmi_addr1;

    logic [1:0]  rsp_valid4, req_busy4, ovf4;
    logic [31:0] rsp_rdata4, dmi_wdata4;
    logic        dmi_valid4, dmi_wr4;
    logic [6:0]  dmi_addr4;

    int n_cmp = 0;
    int n_err = 0;
    int rsp_log[$];
    int iss_log[$];
    int rsp4_cnt = 0;

    always #5 clk = ~clk;

    dmi_arbiter #(.NREQ(2), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
        .rsp_rdata(rsp_rdata1), .req_busy(req_busy1), .ovf(ovf1), .ovf_clr(ovf_clr),
        .dmi_valid(dmi_valid1), .dmi_wr(dmi_wr1), .dmi_addr(dmi_addr1),
        .dmi_wdata(dmi_wdata1), .dmi_rdata(dmi_rdata1)
    );

    dmi_arbiter #(.NREQ(2), .RD_LATENCY(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid4),
        .rsp_rdata(rsp_rdata4), .req_busy(req_busy4), .ovf(ovf4), .ovf_clr(ovf_clr),
        .dmi_valid(dmi_valid4), .dmi_wr(dmi_wr4), .dmi_addr(dmi_addr4),
        .dmi_wdata(dmi_wdata4), .dmi_rdata(dmi_rdata4)
    );

    // Log issues and completions of the RD_LATENCY=1 instance; count any pulse from the other.
    always @(negedge clk) begin
        if (dmi_valid1) iss_log.push_back(int'(dmi_addr1));
        for (int i = 0; i < 2; i++) begin
            if (rsp_valid1[i]) rsp_log.push_back(i);
        end
        if (rsp_valid4 != 2'b00) rsp4_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        req_valid = '0;
        ovf_clr   = '0;
        tick();
        tick();
        resetn = 1'b1;
        rsp_log.delete();
        iss_log.delete();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // Reset values
        resetn = 1'b0;
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid1), 32'h0);
        check("rst_req_busy",  32'(req_busy1), 32'h0);
        check("rst_ovf",       32'(ovf1), 32'h0);
        check("rst_dmi_valid", 32'(dmi_valid1), 32'h0);
        check("rst_dmi_addr",  32'(dmi_addr1), 32'h0);
        check("rst_rsp_rdata", rsp_rdata1, 32'h0);

        // Single read, latency 1: pulse in cycle 0
        do_reset();
        dmi_rdata1     = 32'hDEADBEEF;
        req_addr[6:0]  = 7'h11;
        req_wr         = 2'b00;
        req_valid      = 2'b01;
        tick();                                   // cycle 1
        req_valid = 2'b00;
        check("c1_busy",      32'(req_busy1), 32'h1);
        check("c1_dmi_valid", 32'(dmi_valid1), 32'h0);
        tick();                                   // cycle 2
        check("c2_dmi_valid", 32'(dmi_valid1), 32'h1);
        check("c2_dmi_addr",  32'(dmi_addr1), 32'h11);
        check("c2_dmi_wr",    32'(dmi_wr1), 32'h0);
        tick();                                   // cycle 3
        check("c3_dmi_valid", 32'(dmi_valid1), 32'h0);
        check("c3_rsp_valid", 32'(rsp_valid1), 32'h0);
        tick();                                   // cycle 4
        check("c4_rsp_valid", 32'(rsp_valid1), 32'h1);
        check("c4_rsp_rdata", rsp_rdata1, 32'hDEADBEEF);
        tick();                                   // cycle 5
        check("c5_rsp_valid", 32'(rsp_valid1), 32'h0);
        check("c5_rdata_hold", rsp_rdata1, 32'hDEADBEEF);
        check("c5_busy",      32'(req_busy1), 32'h0);

        // Simultaneous requests after reset: req 0 write, req 1 read
        do_reset();
        req_wr          = 2'b01;
        req_addr[6:0]   = 7'h10;
        req_addr[13:7]  = 7'h04;
        req_wdata[31:0] = 32'h1;
        req_valid       = 2'b11;
        tick();
        req_valid = 2'b00;
        tick();
        check("sim_first_wr",    32'(dmi_wr1), 32'h1);
        check("sim_first_wdata", dmi_wdata1, 32'h1);
        run(12);
        check("sim_rsp_count", 32'(rsp_log.size()), 32'd2);
        check("sim_rsp_0", (rsp_log.size() > 0) ? 32'(rsp_log[0]) : 32'hFFFFFFFF, 32'd0);
        check("sim_rsp_1", (rsp_log.size() > 1) ? 32'(rsp_log[1]) : 32'hFFFFFFFF, 32'd1);
        check("sim_iss_0", (iss_log.size() > 0) ? 32'(iss_log[0]) : 32'hFFFFFFFF, 32'h10);
        check("sim_iss_1", (iss_log.size() > 1) ? 32'(iss_log[1]) : 32'hFFFFFFFF, 32'h04);
        check("sim_last_wr", 32'(dmi_wr1), 32'h0);

        // Round-robin fairness: each requester re-requests on its own completion
        do_reset();
        req_wr    = 2'b00;
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        for (int cyc = 0; cyc < 200 && rsp_log.size() < 20; cyc++) begin
            req_valid = rsp_valid1;
            tick();
        end
        req_valid = 2'b00;
        check("rr_rsp_count", (rsp_log.size() >= 20) ? 32'd20 : 32'(rsp_log.size()), 32'd20);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("rr_order_%0d", k),
                  (k < rsp_log.size()) ? 32'(rsp_log[k]) : 32'hFFFFFFFF, 32'(k % 2));
        end
        check("rr_no_ovf", 32'(ovf1), 32'h0);

        // Overflow: req 1 pulses twice behind an in-flight req 0
        do_reset();
        req_addr[6:0] = 7'h20;
        req_valid     = 2'b01;
        tick();                                   // cycle 1
        req_valid = 2'b00;
        tick();                                   // cycle 2 (ISSUE)
        req_addr[13:7] = 7'h31;
        req_valid      = 2'b10;
        tick();                                   // cycle 3 (WAIT)
        req_addr[13:7] = 7'h32;
        req_valid      = 2'b10;
        tick();                                   // cycle 4
        req_valid = 2'b00;
        check("ovf_set", 32'(ovf1), 32'h2);
        run(10);
        check("ovf_iss_count", 32'(iss_log.size()), 32'd2);
        check("ovf_iss_1", (iss_log.size() > 1) ? 32'(iss_log[1]) : 32'hFFFFFFFF, 32'h31);
        check("ovf_hold", 32'(ovf1), 32'h2);
        ovf_clr = 2'b10;
        tick();
        ovf_clr = 2'b00;
        check("ovf_cleared", 32'(ovf1), 32'h0);

        // Same-cycle refill: req 0 pulses in the cycle its slot is granted
        do_reset();
        req_addr[6:0] = 7'h40;
        req_valid     = 2'b01;
        tick();                                   // cycle 1: granted now
        req_addr[6:0] = 7'h41;
        req_valid     = 2'b01;
        tick();                                   // cycle 2
        req_valid = 2'b00;
        check("refill_no_ovf", 32'(ovf1), 32'h0);
        check("refill_busy",   32'(req_busy1), 32'h1);
        check("refill_addr0",  32'(dmi_addr1), 32'h40);
        run(10);
        check("refill_iss_count", 32'(iss_log.size()), 32'd2);
        check("refill_iss_1", (iss_log.size() > 1) ? 32'(iss_log[1]) : 32'hFFFFFFFF, 32'h41);
        check("refill_rsp_count", 32'(rsp_log.size()), 32'd2);

        // Reset during WAIT on the RD_LATENCY=4 instance
        do_reset();
        dmi_rdata4    = 32'h44440000;
        req_addr[6:0] = 7'h55;
        req_valid     = 2'b01;
        tick();
        req_valid = 2'b00;
        run(3);                                   // cycle 4: WAIT
        check("l4_wait_busy",  32'(req_busy4), 32'h1);
        check("l4_wait_addr",  32'(dmi_addr4), 32'h55);
        rsp4_cnt = 0;
        #2;
        resetn = 1'b0;
        #1;
        check("l4_rst_busy", 32'(req_busy4), 32'h0);
        check("l4_rst_addr", 32'(dmi_addr4), 32'h0);
        check("l4_rst_rsp",  32'(rsp_valid4), 32'h0);
        run(2);
        resetn = 1'b1;
        run(8);
        check("l4_no_rsp", 32'(rsp4_cnt), 32'd0);
        req_addr[6:0] = 7'h56;
        req_valid     = 2'b01;
        tick();                                   // cycle 1
        req_valid = 2'b00;
        run(5);                                   // cycle 6
        check("l4_c6_rsp", 32'(rsp_valid4), 32'h0);
        tick();                                   // cycle 7
        check("l4_c7_rsp",   32'(rsp_valid4), 32'h1);
        check("l4_c7_rdata", rsp_rdata4, 32'h44440000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
